// File: rtl/agro_sensor_monitor.sv
// -----------------------------------------------------------------------------
// agro_sensor_monitor
//
// Purpose:
//   Watches NCH raw sensor lines. Each line goes through a 2-FF synchroniser
//   and a debouncer. The block counts how many filtered channels are active.
//   When that count reaches MIN_ACTIVE, a hold/acknowledge state machine raises
//   a latched alarm and bumps a saturating event counter.
//
// Optional build macro:
//   SENSOR_MASK_EN - adds mask_i. Masked channels are left out of the active
//                    count but still appear on filt_o.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   en           in   monitor enable; low forces the FSM to IDLE
//   sensor_i     in   [NCH] raw asynchronous sensor lines, active-high
//   clr_i        in   alarm acknowledge (pulse or level)
//   mask_i       in   [NCH] channel exclusion mask (SENSOR_MASK_EN only)
//   filt_o       out  [NCH] debounced sensor state
//   active_cnt_o out  [$clog2(NCH+1)] registered count of counted channels
//   alarm_o      out  alarm output
//   event_cnt_o  out  [8] saturating count of alarm entries
//
// FSM states:
//   state   | meaning
//   IDLE    | no alarm; waiting for en && hit
//   ALARM   | alarm raised; minimum hold time running, clr_i ignored
//   LATCH   | alarm held until clr_i, or re-armed by a new hit
// -----------------------------------------------------------------------------
module agro_sensor_monitor #(
    parameter int NCH        = 5,
    parameter int DEB        = 4,
    parameter int MIN_ACTIVE = 3,
    parameter int HOLD       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NCH-1:0]             sensor_i,
    input  logic                       clr_i,
`ifdef SENSOR_MASK_EN
    input  logic [NCH-1:0]             mask_i,
`endif
    output logic [NCH-1:0]             filt_o,
    output logic [$clog2(NCH+1)-1:0]   active_cnt_o,
    output logic                       alarm_o,
    output logic [7:0]                 event_cnt_o
);

    localparam int              CW     = $clog2(NCH + 1);
    localparam logic [7:0]      DEB_C  = 8'(DEB);
    localparam logic [CW-1:0]   MIN_C  = CW'(MIN_ACTIVE);
    localparam logic [15:0]     HOLD_C = 16'(HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALARM = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    logic [NCH-1:0] filt;
    logic [NCH-1:0] counted;
    logic [CW-1:0]  active_d;
    logic [CW-1:0]  active_q;
    logic           hit;
    state_t         state_q;
    logic           alarm_q;
    logic [15:0]    hold_q;
    logic [7:0]     event_q;
    logic [7:0]     event_inc;

    // Two-stage synchroniser for the asynchronous sensor lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sensor_i;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debouncer. The counter counts cycles of disagreement. The
    // filtered bit flips on the cycle the count would reach DEB, so a
    // disagreement must last DEB consecutive cycles.
    for (genvar g = 0; g < NCH; g++) begin : g_deb
        logic [7:0] cnt_q;
        logic [7:0] cnt_inc;
        logic       filt_q;

        assign cnt_inc = cnt_q + 8'd1;
        assign filt[g] = filt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                filt_q <= 1'b0;
            end else if (sync2_q[g] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_inc == DEB_C) begin
                cnt_q  <= '0;
                filt_q <= ~filt_q;
            end else begin
                cnt_q <= cnt_inc;
            end
        end
    end

`ifdef SENSOR_MASK_EN
    assign counted = filt & ~mask_i;
`else
    assign counted = filt;
`endif

    always_comb begin
        active_d = '0;
        for (int i = 0; i < NCH; i++) begin
            active_d = active_d + CW'(counted[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
        end else begin
            active_q <= active_d;
        end
    end

    assign hit       = (active_q >= MIN_C);
    assign event_inc = (event_q == 8'hFF) ? event_q : event_q + 8'd1;

    // Alarm FSM. alarm_q is registered alongside the state so alarm_o is
    // glitch-free and equals (state is ALARM or LATCH).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            alarm_q <= 1'b0;
            hold_q  <= '0;
            event_q <= '0;
        end else if (!en) begin
            state_q <= S_IDLE;
            alarm_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        state_q <= S_ALARM;
                        alarm_q <= 1'b1;
                        hold_q  <= HOLD_C;
                        event_q <= event_inc;
                    end
                end
                S_ALARM: begin
                    alarm_q <= 1'b1;
                    if (hold_q != 16'd0) begin
                        hold_q <= hold_q - 16'd1;
                    end else if (!hit) begin
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    // A fresh hit re-arms the alarm even if acknowledged now.
                    if (hit) begin
                        state_q <= S_ALARM;
                        alarm_q <= 1'b1;
                        hold_q  <= HOLD_C;
                        event_q <= event_inc;
                    end else if (clr_i) begin
                        state_q <= S_IDLE;
                        alarm_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    alarm_q <= 1'b0;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    assign filt_o       = filt;
    assign active_cnt_o = active_q;
    assign alarm_o      = alarm_q;
    assign event_cnt_o  = event_q;

endmodule

// File: tb/tb_agro_sensor_monitor.sv
module tb_agro_sensor_monitor;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [4:0] sensor;
    logic       clr;
    logic [4:0] mask;
    logic [4:0] filt_o;
    logic [2:0] active_cnt_o;
    logic       alarm_o;
    logic [7:0] event_cnt_o;

    int n_cmp;
    int n_err;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    agro_sensor_monitor #(
        .NCH(5), .DEB(4), .MIN_ACTIVE(3), .HOLD(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sensor_i    (sensor),
        .clr_i       (clr),
`ifdef SENSOR_MASK_EN
        .mask_i      (mask),
`endif
        .filt_o      (filt_o),
        .active_cnt_o(active_cnt_o),
        .alarm_o     (alarm_o),
        .event_cnt_o (event_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Push an expectation into the scoreboard.
    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    // Pop the oldest expectation and compare against the observed value.
    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL sb_underflow observed=%0d expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        en     = 1'b1;
        sensor = 5'b0;
        clr    = 1'b0;
        mask   = 5'b0;
        tick(2);

        // Reset values
        expect_val("rst_filt", 0);   check(32'(filt_o));
        expect_val("rst_cnt", 0);    check(32'(active_cnt_o));
        expect_val("rst_alarm", 0);  check(32'(alarm_o));
        expect_val("rst_event", 0);  check(32'(event_cnt_o));

        // Test 1: three channels active, latency chain
        rst_n  = 1'b1;
        sensor = 5'b00111;
        expect_val("t1_filt_e5", 0);
        tick(5); check(32'(filt_o));
        expect_val("t1_filt_e6", 5'b00111);
        expect_val("t1_cnt_e6", 0);
        tick(1); check(32'(filt_o)); check(32'(active_cnt_o));
        expect_val("t1_cnt_e7", 3);
        expect_val("t1_alarm_e7", 0);
        tick(1); check(32'(active_cnt_o)); check(32'(alarm_o));
        expect_val("t1_alarm_e8", 1);
        expect_val("t1_event_e8", 1);
        tick(1); check(32'(alarm_o)); check(32'(event_cnt_o));

        // Test 3: drop sensors; hold runs 16 ALARM cycles, clr ignored there
        sensor = 5'b0;
        expect_val("t3_alarm_e20", 1);
        tick(12); check(32'(alarm_o));
        clr = 1'b1;
        expect_val("t3_alarm_clr_in_alarm", 1);
        tick(1); check(32'(alarm_o));
        clr = 1'b0;
        expect_val("t3_alarm_e23", 1);
        tick(2); check(32'(alarm_o));
        clr = 1'b1;
        expect_val("t3_alarm_clr_last_alarm", 1);
        tick(1); check(32'(alarm_o));
        clr = 1'b0;
        expect_val("t3_alarm_latch", 1);
        expect_val("t3_event_latch", 1);
        tick(1); check(32'(alarm_o)); check(32'(event_cnt_o));

        // Test 4: in LATCH, hit and clr arrive together; hit wins
        sensor = 5'b00111;
        expect_val("t4_alarm_pre", 1);
        expect_val("t4_cnt_pre", 3);
        tick(7); check(32'(alarm_o)); check(32'(active_cnt_o));
        clr = 1'b1;
        expect_val("t4_alarm_reenter", 1);
        expect_val("t4_event_reenter", 2);
        tick(1); check(32'(alarm_o)); check(32'(event_cnt_o));
        clr = 1'b0;
        expect_val("t4_alarm_after", 1);
        tick(1); check(32'(alarm_o));
        sensor = 5'b0;
        expect_val("t4_alarm_latch", 1);
        tick(20); check(32'(alarm_o));
        clr = 1'b1;
        expect_val("t4_alarm_cleared", 0);
        expect_val("t4_event_cleared", 2);
        tick(1); check(32'(alarm_o)); check(32'(event_cnt_o));
        clr = 1'b0;

        // Test 2: 3-cycle glitch never reaches filt
        sensor = 5'b00001;
        tick(3);
        sensor = 5'b0;
        expect_val("t2_filt_e6", 0);
        tick(3); check(32'(filt_o));
        expect_val("t2_filt_end", 0);
        expect_val("t2_cnt_end", 0);
        expect_val("t2_alarm_end", 0);
        tick(7); check(32'(filt_o)); check(32'(active_cnt_o)); check(32'(alarm_o));

        // Boundary: exactly DEB cycles does flip filt
        sensor = 5'b00010;
        tick(4);
        sensor = 5'b0;
        expect_val("t2b_filt_e6", 5'b00010);
        tick(2); check(32'(filt_o));
        expect_val("t2b_cnt_e7", 1);
        tick(1); check(32'(active_cnt_o));
        expect_val("t2b_filt_end", 0);
        expect_val("t2b_cnt_end", 0);
        expect_val("t2b_alarm_end", 0);
        tick(8); check(32'(filt_o)); check(32'(active_cnt_o)); check(32'(alarm_o));

        // Test 5: en drop for one cycle in ALARM
        sensor = 5'b00111;
        expect_val("t5_alarm_on", 1);
        expect_val("t5_event_on", 3);
        tick(8); check(32'(alarm_o)); check(32'(event_cnt_o));
        tick(2);
        en = 1'b0;
        expect_val("t5_alarm_en_low", 0);
        expect_val("t5_event_en_low", 3);
        tick(1); check(32'(alarm_o)); check(32'(event_cnt_o));
        en = 1'b1;
        expect_val("t5_alarm_reen", 1);
        expect_val("t5_event_reen", 4);
        tick(1); check(32'(alarm_o)); check(32'(event_cnt_o));

        // Back to IDLE with no hit
        sensor = 5'b0;
        en     = 1'b0;
        tick(8);
        en = 1'b1;
        expect_val("t5_idle_alarm", 0);
        expect_val("t5_idle_event", 4);
        tick(1); check(32'(alarm_o)); check(32'(event_cnt_o));

        // Test 6: 300 alarm entries, event counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            sensor = 5'b00111;
            expect_val("t6_event", ((5 + i) > 255) ? 255 : (5 + i));
            tick(8); check(32'(event_cnt_o));
            sensor = 5'b0;
            tick(17);
            clr = 1'b1;
            expect_val("t6_alarm_clr", 0);
            tick(1); check(32'(alarm_o));
            clr = 1'b0;
        end
        expect_val("t6_event_final", 255);
        check(32'(event_cnt_o));

        // Async reset in the middle of an alarm
        sensor = 5'b00111;
        expect_val("t6_alarm_before_rst", 1);
        tick(10); check(32'(alarm_o));
        rst_n = 1'b0;
        #1;
        expect_val("rst_mid_alarm", 0);
        expect_val("rst_mid_event", 0);
        expect_val("rst_mid_filt", 0);
        expect_val("rst_mid_cnt", 0);
        check(32'(alarm_o)); check(32'(event_cnt_o));
        check(32'(filt_o)); check(32'(active_cnt_o));
        tick(1);
        rst_n = 1'b1;
        expect_val("rel_filt_e5", 0);
        tick(5); check(32'(filt_o));
        expect_val("rel_filt_e6", 5'b00111);
        tick(1); check(32'(filt_o));
        expect_val("rel_alarm_e7", 0);
        tick(1); check(32'(alarm_o));
        expect_val("rel_alarm_e8", 1);
        expect_val("rel_event_e8", 1);
        tick(1); check(32'(alarm_o)); check(32'(event_cnt_o));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
